// File: rtl/lut_pkg.sv
// lut_pkg: types and constants shared by the LUT phase sequencer and the
// LUT waveform stages that consume its table index.
package lut_pkg;

    // Entries per waveform period.
    localparam int LUT_TABLE_LEN_DEF = 360;

    // Width of the table index bus shared with the LUT waveform stages.
    localparam int LUT_COUNT_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lut_state_e;

endpackage

// File: rtl/lut_step_prescaler.sv
// lut_step_prescaler: loadable down-counter that emits one step tick every
// (reload_val + 1) enabled clocks. clr has priority over load, and load has
// priority over run. tick is combinational from the count register.
module lut_step_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] reload_val,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = run && (cnt_q == '0);

    // Next count: clear, explicit load, or count down with auto-reload at zero.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = reload_val;
        end else if (run) begin
            cnt_d = (cnt_q == '0) ? reload_val : cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lut_phase_sequencer.sv
// lut_phase_sequencer: generates the table index for the LUT waveform stages,
// stepping once every cur_div clocks and wrapping at TABLE_LEN-1. New
// divisors are buffered in a one-entry pending slot and applied only in IDLE
// or on the wrap edge, so a period always has a constant length. After
// note-off the current period is finished (DRAIN) before returning to IDLE.
// Optional feature: define LUT_WRAP_PULSE_EN to add the registered wrap strobe.
module lut_phase_sequencer
    import lut_pkg::*;
#(
    parameter int TABLE_LEN = LUT_TABLE_LEN_DEF,
    parameter int DIV_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   note_on,
    input  logic                   note_valid,
    output logic                   note_ready,
    input  logic [DIV_W-1:0]       note_div,
    output logic [LUT_COUNT_W-1:0] table_count,
    output logic                   step,
`ifdef LUT_WRAP_PULSE_EN
    output logic                   wrap,
`endif
    output logic                   active
);

    localparam logic [LUT_COUNT_W-1:0] LAST_IDX = LUT_COUNT_W'(TABLE_LEN - 1);

    lut_state_e             state_q,     state_d;
    logic [DIV_W-1:0]       cur_div_q,   cur_div_d;
    logic [DIV_W-1:0]       pend_div_q,  pend_div_d;
    logic                   pend_full_q, pend_full_d;
    logic [LUT_COUNT_W-1:0] count_q,     count_d;
    logic                   step_q,      step_d;
    logic                   active_q,    active_d;
`ifdef LUT_WRAP_PULSE_EN
    logic                   wrap_q,      wrap_d;
`endif

    logic             tick;
    logic             at_last;
    logic             wrap_evt;
    logic             promote;
    logic             presc_clr;
    logic             presc_load;
    logic             presc_run;
    logic [DIV_W-1:0] reload_val;

    assign note_ready  = !pend_full_q;
    assign table_count = count_q;
    assign step        = step_q;
    assign active      = active_q;
`ifdef LUT_WRAP_PULSE_EN
    assign wrap        = wrap_q;
`endif

    // The prescaler runs only while playing; its tick must not depend on the
    // next state, which itself depends on the tick.
    assign presc_run  = en && (state_q != ST_IDLE);
    assign presc_load = en && (state_q == ST_IDLE) && (state_d == ST_RUN);
    assign presc_clr  = en && (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign at_last    = (count_q == LAST_IDX);
    assign wrap_evt   = tick && at_last;

    // A divisor promoted on this edge already governs the next step interval.
    assign reload_val = (promote ? pend_div_q : cur_div_q) - 1'b1;

    lut_step_prescaler #(
        .W (DIV_W)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .clr        (presc_clr),
        .load       (presc_load),
        .run        (presc_run),
        .reload_val (reload_val),
        .tick       (tick)
    );

    // Next-state logic: FSM, pending-divisor slot, index counter and strobes.
    always_comb begin
        state_d     = state_q;
        cur_div_d   = cur_div_q;
        pend_div_d  = pend_div_q;
        pend_full_d = pend_full_q;
        count_d     = count_q;
        step_d      = 1'b0;
        promote     = 1'b0;
`ifdef LUT_WRAP_PULSE_EN
        wrap_d      = 1'b0;
`endif

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    promote = pend_full_q;
                    if (note_on && (cur_div_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    promote = pend_full_q && wrap_evt;
                    if (!note_on) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    promote = pend_full_q && wrap_evt;
                    if (wrap_evt) begin
                        state_d = note_on ? ST_RUN : ST_IDLE;
                    end else if (note_on) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (tick) begin
                count_d = at_last ? '0 : count_q + 1'b1;
                step_d  = 1'b1;
`ifdef LUT_WRAP_PULSE_EN
                wrap_d  = at_last;
`endif
            end
        end

        if (promote) begin
            cur_div_d   = pend_div_q;
            pend_full_d = 1'b0;
        end

        // Handshakes complete regardless of en; a zero divisor means one clock.
        if (note_valid && !pend_full_q) begin
            pend_div_d  = (note_div == '0) ? DIV_W'(1) : note_div;
            pend_full_d = 1'b1;
        end
    end

    assign active_d = (state_d != ST_IDLE);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cur_div_q   <= '0;
            pend_div_q  <= '0;
            pend_full_q <= 1'b0;
            count_q     <= '0;
            step_q      <= 1'b0;
            active_q    <= 1'b0;
`ifdef LUT_WRAP_PULSE_EN
            wrap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_div_q   <= cur_div_d;
            pend_div_q  <= pend_div_d;
            pend_full_q <= pend_full_d;
            count_q     <= count_d;
            step_q      <= step_d;
            active_q    <= active_d;
`ifdef LUT_WRAP_PULSE_EN
            wrap_q      <= wrap_d;
`endif
        end
    end

endmodule

// File: tb/tb_lut_phase_sequencer.sv
// Testbench for lut_phase_sequencer. Stimulus applied on the falling edge
// feeds a behavioural model; expected outputs go into a queue and a separate
// monitor compares them after each rising edge.
`timescale 1ns/1ps
module tb_lut_phase_sequencer;

    localparam int TLEN = 360;
    localparam int DW   = 16;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          en         = 1'b0;
    logic          note_on    = 1'b0;
    logic          note_valid = 1'b0;
    logic [DW-1:0] note_div   = '0;
    logic          note_ready;
    logic [15:0]   table_count;
    logic          step;
    logic          active;
`ifdef LUT_WRAP_PULSE_EN
    logic          wrap;
`endif

    lut_phase_sequencer #(
        .TABLE_LEN (TLEN),
        .DIV_W     (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .note_on     (note_on),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_div    (note_div),
        .table_count (table_count),
        .step        (step),
`ifdef LUT_WRAP_PULSE_EN
        .wrap        (wrap),
`endif
        .active      (active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    int m_mode, m_cur, m_pend, m_idx, m_elapsed;
    bit m_pend_full, m_step, m_wrap;

    task automatic model_reset();
        m_mode = M_IDLE; m_cur = 0; m_pend = 0; m_pend_full = 0;
        m_idx = 0; m_elapsed = 0; m_step = 0; m_wrap = 0;
    endtask

    // One rising edge of the reference: elapsed counts clocks since the last
    // step (or since starting), a step fires when it equals the divisor.
    task automatic model_clock();
        bit hs;
        int old_cur;
        hs = note_valid && !m_pend_full;
        m_step = 0;
        m_wrap = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (en) begin
            if (m_mode == M_IDLE) begin
                old_cur = m_cur;
                if (m_pend_full) begin
                    m_cur = m_pend;
                    m_pend_full = 0;
                end
                if (note_on && old_cur != 0) begin
                    m_mode = M_RUN;
                    m_elapsed = 0;
                end
            end else begin
                m_elapsed++;
                if (m_elapsed == m_cur) begin
                    m_elapsed = 0;
                    m_step = 1;
                    m_idx = (m_idx + 1) % TLEN;
                    m_wrap = (m_idx == 0);
                end
                if (m_wrap && m_pend_full) begin
                    m_cur = m_pend;
                    m_pend_full = 0;
                end
                if (m_mode == M_RUN) begin
                    if (!note_on) m_mode = M_DRAIN;
                end else if (m_wrap) begin
                    m_mode = note_on ? M_RUN : M_IDLE;
                end else if (note_on) begin
                    m_mode = M_RUN;
                end
            end
        end
        if (hs) begin
            m_pend = (note_div == 0) ? 1 : int'(note_div);
            m_pend_full = 1;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] e_idx;
        logic        e_step;
        logic        e_active;
        logic        e_ready;
        logic        e_wrap;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_expected();
        exp_t e;
        e.e_idx    = 16'(m_idx);
        e.e_step   = m_step;
        e.e_active = (m_mode != M_IDLE);
        e.e_ready  = !m_pend_full;
        e.e_wrap   = m_wrap;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented output cycle against the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("table_count", table_count, e.e_idx);
                check("step", step, e.e_step);
                check("active", active, e.e_active);
                check("note_ready", note_ready, e.e_ready);
`ifdef LUT_WRAP_PULSE_EN
                check("wrap", wrap, e.e_wrap);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic          s_rst = 1'b0, s_en = 1'b0, s_on = 1'b0, s_valid = 1'b0;
    logic [DW-1:0] s_div = '0;

    task automatic tick();
        @(negedge clk);
        rst        = s_rst;
        en         = s_en;
        note_on    = s_on;
        note_valid = s_valid;
        note_div   = s_div;
        model_clock();
        push_expected();
    endtask

    task automatic offer(input int d);
        s_valid = 1'b1;
        s_div   = DW'(d);
        tick();
        s_valid = 1'b0;
    endtask

    // Advance until the model has just stepped onto index target.
    task automatic run_until_idx(input int target, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(m_idx == target && m_step) && n < budget);
        check($sformatf("reach_idx_%0d", target), (m_idx == target && m_step), 1);
    endtask

    // Assert reset between clock edges and look at outputs before any edge.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_table_count", table_count, 0);
        check("async_rst_step", step, 0);
        check("async_rst_active", active, 0);
        check("async_rst_note_ready", note_ready, 1);
`ifdef LUT_WRAP_PULSE_EN
        check("async_rst_wrap", wrap, 0);
`endif
        s_rst = 1'b0;
        model_reset();
        push_expected();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        s_en = 1'b1;
        repeat (3) tick();
        s_rst = 1'b1;
        tick();

        // div = 4, continuous playback through one full period and beyond.
        offer(4);
        s_on = 1'b1;
        run_until_idx(0, 2000);
        run_until_idx(100, 1000);

        // Pitch change mid-period: applied only at the wrap.
        offer(2);
        run_until_idx(0, 2000);
        run_until_idx(50, 500);

        // en low freezes everything for 10 clocks.
        s_en = 1'b0;
        repeat (10) tick();
        s_en = 1'b1;

        // div = 1 then note-off at 200: finish the period and go idle.
        offer(1);
        run_until_idx(0, 1000);
        run_until_idx(200, 500);
        s_on = 1'b0;
        run_until_idx(0, 500);
        repeat (5) tick();

        // div = 0 behaves as div = 1.
        offer(0);
        tick();
        s_on = 1'b1;
        repeat (400) tick();

        // Randomised note, enable and divisor traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(249, 0) == 0) s_on = ~s_on;
            s_en    = ($urandom_range(15, 0) != 0);
            s_valid = ($urandom_range(39, 0) == 0);
            s_div   = DW'($urandom_range(3, 0));
            tick();
        end

        // Mid-period reset at 123 with a divisor pending; afterwards nothing plays.
        s_valid = 1'b0;
        s_en    = 1'b1;
        s_on    = 1'b1;
        run_until_idx(123, 3000);
        if (note_ready) offer(2);
        mid_reset();
        repeat (2) tick();
        s_rst = 1'b1;
        repeat (8) tick();

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_phase_sequencer.md
# lut_phase_sequencer

Table-address generator for the LUT waveform stages that drive the R2R DAC on the PMOD header. It produces the `table_count` index those stages consume, stepping it once every `note_div` clocks through 0..TABLE_LEN-1 so one wrap equals one output period. It accepts pitch updates over a valid/ready handshake, applies them only at a period boundary, and finishes the current period after note-off so the DAC never stops mid-cycle.

## Interface

- `TABLE_LEN`, 360: entries per waveform period; the count wraps at TABLE_LEN-1.
- `DIV_W`, 16: width of the clocks-per-step divisor.

- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `en`  input  1  global run gate; low freezes the prescaler, count and state.
- `note_on`  input  1  level; high requests playback.
- `note_valid`  input  1  `note_div` is offered.
- `note_ready`  output  1  pending-divisor slot is empty.
- `note_div`  input  DIV_W  clocks per table step.
- `table_count`  output  16  current table index for the LUT stages.
- `step`  output  1  one-cycle pulse on every `table_count` change.
- `active`  output  1  high in RUN or DRAIN.
- `wrap`  output  1  one-cycle pulse when the count goes from TABLE_LEN-1 to 0. Present only with `LUT_WRAP_PULSE_EN`.

## Operation

- The handshake completes when `note_valid && note_ready` at a rising edge. `note_div` is then captured into `pend_div` and `pend_full` is set. `note_ready = !pend_full`.
- A captured divisor of 0 is stored as 1.
- `pend_div` is promoted to `cur_div` in two cases:
  - immediately while in IDLE;
  - otherwise on the wrap edge.
- Promotion clears `pend_full`. A handshake in the same cycle as a promotion is not possible because `note_ready` is low.
- States:
  - IDLE: `table_count = 0`, prescaler = 0. Moves to RUN when `note_on && en` and `cur_div != 0`. `cur_div` resets to 0, so no divisor means no playback.
  - RUN: on entry the prescaler loads `cur_div - 1`. Each enabled clock it decrements. When it reaches 0 it reloads and `table_count` advances with wrap to 0. Falling `note_on` moves the block to DRAIN.
  - DRAIN: counting continues. At the wrap edge the block goes to IDLE, or back to RUN if `note_on` has risen again. A rising `note_on` before the wrap goes straight back to RUN with no reset of the count.
- `en` low holds all registers. `step` and `wrap` are 0 while `en` is low. Handshakes still complete.
- `cur_div` only changes at a wrap or in IDLE, so the period length inside one cycle is constant.

## Timing

- Reset values: `table_count = 0`, `step = 0`, `wrap = 0`, `active = 0`, `note_ready = 1`. Internally `cur_div = 0`, `pend_full = 0`, state = IDLE.
- From `note_on` high in IDLE to `active` high: 1 clock.
- The first `step` pulse comes `cur_div` clocks after RUN entry.
- Step period is exactly `cur_div` enabled clocks, so one waveform period is `TABLE_LEN * cur_div` clocks.
- `step`, `wrap` and `table_count` update on the same edge. All outputs are registered; there is no combinational input-to-output path except `note_ready`, which comes from a register.
- With `div = 1`, `table_count` advances every clock and `step` stays high continuously.
- Simultaneous wrap, `note_on` fall and pending divisor: the promotion happens and the state goes to DRAIN. The new divisor applies to the drain period.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronous). The pending divisor is lost.

## Configuration

- `LUT_WRAP_PULSE_EN` defined: the `wrap` port and its register exist. Downstream blocks use it as a period-sync strobe, for example for oscillator hard-sync or a scope trigger.
- `LUT_WRAP_PULSE_EN` undefined: the port and register are absent. All other behaviour is identical.

## Structure

- Shared package `lut_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - `LUT_TABLE_LEN_DEF = 360`;
  - the `table_count` width constant (16), shared with the LUT waveform stages.
- One sub-module, `lut_step_prescaler`. It is the loadable down-counter with enable that emits the step tick. The top level holds the FSM, the pending buffer and the index counter.

## Test plan

- Reset, then `div = 4` and `note_on` held high: `step` pulses every 4 clocks, `table_count` runs 0..359 then returns to 0, and `wrap` pulses once per 1440 clocks.
- While running at `div = 4`, send `div = 2` at count 100: `note_ready` drops, the step spacing stays 4 until the wrap, then becomes 2, and `note_ready` returns high.
- Drop `note_on` at count 200 with `div = 1`: counting continues to 359, goes to 0, and `active` falls on the wrap edge with `table_count = 0`.
- Send `div = 0` then `note_on`: the step fires every clock, identical to `div = 1`.
- Pull `en` low for 10 clocks at count 50: the count holds at 50, no `step` pulses occur, and counting resumes with the prescaler phase preserved.
- Assert `rst` low mid-period at count 123: all outputs go to their reset values within the same cycle, without waiting for a clock, and `note_ready` is 1.
